// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner of one shared WIDTH-bit register among four requesters.
// Latency: gnt one cycle after req is seen in IDLE; q loads on the first edge of an owner write.
// Backpressure: the owner keeps the register while req stays high (bounded by MAX_HOLD when
// SHARED_REG_TIMEOUT_EN is defined); every ownership ends with one RELEASE and one IDLE cycle.
module shared_reg_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [3:0]         wr,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qn,
  output logic               timeout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             timeout_q, timeout_d;

  logic             pick_vld;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic [WIDTH-1:0] owner_lane;
  logic             own_req;
  logic             own_wr;
  logic             hold_at_limit;
  logic             force_rel;

  assign owner_lane    = wdata[owner_q*WIDTH +: WIDTH];
  assign own_req       = req[owner_q];
  assign own_wr        = wr[owner_q];
  assign hold_at_limit = (hold_q == HOLD_LAST);

`ifdef SHARED_REG_TIMEOUT_EN
  assign force_rel = hold_at_limit;
`else
  assign force_rel = 1'b0;
`endif

  // First requesting index at or after ptr; scanned from the far end so the nearest wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state, grant, pointer, hold counter and register write decisions.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    reg_d     = reg_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << pick_idx;
          owner_d = pick_idx;
          hold_d  = 8'd0;
        end
      end
      ST_GRANT: begin
        if (!own_req) begin
          // Owner let go: no write this cycle, hand the pointer past it.
          state_d = ST_RELEASE;
          gnt_d   = 4'b0000;
          ptr_d   = owner_q + 2'd1;
        end else begin
          if (own_wr) begin
            reg_d = owner_lane;
          end
          if (force_rel) begin
            state_d   = ST_RELEASE;
            gnt_d     = 4'b0000;
            ptr_d     = owner_q + 2'd1;
            timeout_d = 1'b1;
          end else if (!hold_at_limit) begin
            // Saturates when no hold limit is enforced.
            hold_d = hold_q + 8'd1;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including the shared register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      gnt_q     <= 4'b0000;
      owner_q   <= 2'd0;
      reg_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      reg_q     <= reg_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q != ST_IDLE);
  assign q       = reg_q;
  assign qn      = ~reg_q;
  assign timeout = timeout_q;

endmodule
